video_pattern_gen: RTL and testbench

Avalon-ST video source that generates complete RGB565 frames (solid colour, colour bars, gradient, checkerboard) under control of an Avalon-MM slave register file. It is the transmitting end of the 16-bit video stream consumed by the video effects IP sink. It drives that sink directly for bring-up and verification without a camera, and can stay in the system as a test-pattern source.

---
 rtl/video_pattern_gen_if.sv | 35 +++
 rtl/video_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if
//   Bundles the Avalon-MM register port and the Avalon-ST RGB565 stream of
//   video_pattern_gen.
//   slave  : pattern generator view (MM slave, ST source).
//   master : system/host view (drives MM, consumes ST, drives ready_in).
//   MM : chipselect, address[1:0], write, writedata[31:0], read, readdata[31:0]
//   ST : valid_out, ready_in, data_out[15:0], startofpacket_out, endofpacket_out
interface video_pattern_gen_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  logic        valid_out;
  logic        ready_in;
  logic [15:0] data_out;
  logic        startofpacket_out;
  logic        endofpacket_out;

  modport slave (
    input  chipselect, address, write, writedata, read,
    output readdata,
    output valid_out, data_out, startofpacket_out, endofpacket_out,
    input  ready_in
  );

  modport master (
    output chipselect, address, write, writedata, read,
    input  readdata,
    input  valid_out, data_out, startofpacket_out, endofpacket_out,
    output ready_in
  );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Avalon-ST source of complete RGB565 frames (solid, colour bars, grey ramp,
//   checkerboard), configured through a small Avalon-MM register file.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : video_pattern_gen_if.slave (MM registers + ST stream)
//   Registers:
//     0 : [0] enable, [1] single_shot
//     1 : [1:0] pattern_sel, [31:16] solid_color
//     2 : read-only [0] busy, [31:16] frame_count
//     3 : reserved, reads 0
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no frame in flight, valid_out low, waiting for enable
//   ST_ACTIVE | streaming a frame; the registered beat is (x_q, y_q)
module video_pattern_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input logic                clk,
  input logic                reset,
  video_pattern_gen_if.slave bus
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = ((WIDTH / 8) > 1) ? $clog2(WIDTH / 8) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(WIDTH / 8 - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t        state_q, state_d;
  logic          enable_q, enable_d;
  logic          single_shot_q, single_shot_d;
  logic [1:0]    pattern_sel_q, pattern_sel_d;
  logic [15:0]   solid_color_q, solid_color_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [1:0]    shadow_pat_q, shadow_pat_d;
  logic [15:0]   shadow_col_q, shadow_col_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic          valid_q, valid_d;
  logic [15:0]   data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;

  logic          wr_reg0, wr_reg1, xfer, last_beat, busy;
  logic          load_beat;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [BW-1:0] nb_cnt;
  logic [2:0]    nb_idx;
  logic [1:0]    npat;
  logic [15:0]   ncol;
  logic          unused_wdata;

  // Bar colour comes from bar_idx, which advances when the per-bar
  // down-counter hits zero, so no divide by WIDTH/8 is needed.
  function automatic logic [15:0] pixel(input logic [1:0]    pat,
                                        input logic [15:0]   col,
                                        input logic [XW-1:0] x,
                                        input logic [YW-1:0] y,
                                        input logic [2:0]    bar);
    logic [5:0] g;
    logic       y_b3;
    g    = 6'(x);
    y_b3 = |(4'(y) & 4'b1000);
    pixel = 16'h0000;
    case (pat)
      2'd0: pixel = col;
      2'd1: begin
        case (bar)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd2:    pixel = {g[5:1], g, g[5:1]};
      default: pixel = (g[3] ^ y_b3) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  assign wr_reg0   = bus.chipselect & bus.write & (bus.address == 2'd0);
  assign wr_reg1   = bus.chipselect & bus.write & (bus.address == 2'd1);
  assign xfer      = valid_q & bus.ready_in;
  assign last_beat = (x_q == X_LAST) && (y_q == Y_LAST);
  assign busy      = (state_q == ST_ACTIVE);

  assign unused_wdata = ^bus.writedata[15:2];

  always_comb begin
    bus.readdata = 32'h0;
    if (bus.chipselect & bus.read) begin
      case (bus.address)
        2'd0:    bus.readdata = {30'h0, single_shot_q, enable_q};
        2'd1:    bus.readdata = {solid_color_q, 14'h0, pattern_sel_q};
        2'd2:    bus.readdata = {frame_count_q, 15'h0, busy};
        default: bus.readdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    single_shot_d = single_shot_q;
    pattern_sel_d = pattern_sel_q;
    solid_color_d = solid_color_q;
    frame_count_d = frame_count_q;
    shadow_pat_d  = shadow_pat_q;
    shadow_col_d  = shadow_col_q;
    x_d           = x_q;
    y_d           = y_q;
    bar_cnt_d     = bar_cnt_q;
    bar_idx_d     = bar_idx_q;
    valid_d       = valid_q;
    data_d        = data_q;
    sop_d         = sop_q;
    eop_d         = eop_q;
    load_beat     = 1'b0;
    nx            = '0;
    ny            = '0;
    nb_cnt        = BAR_LAST;
    nb_idx        = 3'd0;
    npat          = shadow_pat_q;
    ncol          = shadow_col_q;

    if (wr_reg0) begin
      enable_d      = bus.writedata[0];
      single_shot_d = bus.writedata[1];
    end
    if (wr_reg1) begin
      pattern_sel_d = bus.writedata[1:0];
      solid_color_d = bus.writedata[31:16];
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d      = ST_ACTIVE;
          load_beat    = 1'b1;
          npat         = pattern_sel_q;
          ncol         = solid_color_q;
          shadow_pat_d = pattern_sel_q;
          shadow_col_d = solid_color_q;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          if (last_beat) begin
            frame_count_d = frame_count_q + 16'd1;
            // Frame end beats a same-cycle reg0 write for single_shot.
            if (single_shot_q) begin
              enable_d      = 1'b0;
              single_shot_d = 1'b0;
            end
            if (enable_d) begin
              load_beat    = 1'b1;
              npat         = pattern_sel_q;
              ncol         = solid_color_q;
              shadow_pat_d = pattern_sel_q;
              shadow_col_d = solid_color_q;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              data_d  = 16'h0000;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
            end
          end else begin
            load_beat = 1'b1;
            if (x_q == X_LAST) begin
              nx     = '0;
              ny     = y_q + YW'(1);
              nb_cnt = BAR_LAST;
              nb_idx = 3'd0;
            end else begin
              nx = x_q + XW'(1);
              ny = y_q;
              if (bar_cnt_q == '0) begin
                nb_cnt = BAR_LAST;
                nb_idx = bar_idx_q + 3'd1;
              end else begin
                nb_cnt = bar_cnt_q - BW'(1);
                nb_idx = bar_idx_q;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_beat) begin
      x_d       = nx;
      y_d       = ny;
      bar_cnt_d = nb_cnt;
      bar_idx_d = nb_idx;
      valid_d   = 1'b1;
      data_d    = pixel(npat, ncol, nx, ny, nb_idx);
      sop_d     = (nx == '0) && (ny == '0);
      eop_d     = (nx == X_LAST) && (ny == Y_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      single_shot_q <= 1'b0;
      pattern_sel_q <= 2'd0;
      solid_color_q <= 16'h0000;
      frame_count_q <= 16'h0000;
      shadow_pat_q  <= 2'd0;
      shadow_col_q  <= 16'h0000;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= 3'd0;
      valid_q       <= 1'b0;
      data_q        <= 16'h0000;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      single_shot_q <= single_shot_d;
      pattern_sel_q <= pattern_sel_d;
      solid_color_q <= solid_color_d;
      frame_count_q <= frame_count_d;
      shadow_pat_q  <= shadow_pat_d;
      shadow_col_q  <= shadow_col_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
    end
  end

  assign bus.valid_out         = valid_q;
  assign bus.data_out          = data_q;
  assign bus.startofpacket_out = sop_q;
  assign bus.endofpacket_out   = eop_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//   Drives video_pattern_gen (16x4 frames) through its register port with
//   random backpressure and compares every transferred pixel against a
//   reference computed from the pattern rules on the frame-relative index.
module tb_video_pattern_gen;
  localparam int W = 16;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;

  video_pattern_gen_if bus ();

  video_pattern_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // register-level model
  bit          m_en, m_ss;
  logic [1:0]  m_pat;
  logic [15:0] m_col;
  int          m_fc;

  int          act_beat [2];
  logic [1:0]  act_addr [2];
  logic [31:0] act_data [2];

  logic [15:0] bar_col [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_pixel(input logic [1:0] pat, input logic [15:0] col, input int k);
    int x, y, g, v;
    x = k % W;
    y = k / W;
    case (pat)
      2'd0: v = int'(col);
      2'd1: v = int'(bar_col[x / (W / 8)]);
      2'd2: begin
        g = x % 64;
        v = ((g / 2) * 2048) + (g * 32) + (g / 2);
      end
      default: v = ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 32'hFFFF : 0;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [31:0] reg1_val();
    return {m_col, 14'h0, m_pat};
  endfunction

  function automatic logic [31:0] reg2_val(input bit busy);
    logic [15:0] fc;
    fc = m_fc[15:0];
    return {fc, 15'h0, busy};
  endfunction

  task automatic apply_write(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd0) begin
      m_en = d[0];
      m_ss = d[1];
    end else if (a == 2'd1) begin
      m_pat = d[1:0];
      m_col = d[31:16];
    end
  endtask

  task automatic frame_end();
    m_fc = (m_fc + 1) % 65536;
    if (m_ss) begin
      m_en = 1'b0;
      m_ss = 1'b0;
    end
  endtask

  // starts and ends on a falling edge
  task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    apply_write(a, d);
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic mm_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    #1;
    chk(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  // write reg0 in cycle T; idle at T+1, sop beat visible at T+2
  task automatic start(input logic [31:0] d);
    mm_write(2'd0, d);
    chk("lat_t1_valid", {31'h0, bus.valid_out}, 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", {31'h0, bus.valid_out}, 32'd1);
    chk("lat_t2_sop", {31'h0, bus.startofpacket_out}, 32'd1);
  endtask

  task automatic clear_acts();
    for (int i = 0; i < 2; i++) act_beat[i] = -1;
  endtask

  task automatic stream_frame(input int pct, input int abort_beat);
    logic [1:0]  s_pat;
    logic [15:0] s_col;
    int          k, cyc;
    bit          done, stall;
    bit          used [2];
    logic [17:0] held, now;
    s_pat = m_pat;
    s_col = m_col;
    k = 0; cyc = 0; done = 0; stall = 0; held = '0;
    used[0] = 0; used[1] = 0;
    while (!done && cyc < 20 * N) begin
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!used[i] && act_beat[i] == k && !bus.write) begin
          bus.chipselect = 1'b1;
          bus.write      = 1'b1;
          bus.address    = act_addr[i];
          bus.writedata  = act_data[i];
          apply_write(act_addr[i], act_data[i]);
          used[i] = 1;
        end
      end
      bus.ready_in = ($urandom_range(0, 99) < pct);
      if (k == abort_beat) bus.ready_in = 1'b0;
      #1;
      now = {bus.data_out, bus.startofpacket_out, bus.endofpacket_out};
      if (stall) chk("hold", 32'(now), 32'(held));
      chk("valid", {31'h0, bus.valid_out}, 32'd1);
      if (k == abort_beat) begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        reset          = 1'b1;
        return;
      end
      if (bus.valid_out && bus.ready_in) begin
        chk("pix", {16'h0, bus.data_out}, {16'h0, exp_pixel(s_pat, s_col, k)});
        chk("sop", {31'h0, bus.startofpacket_out}, {31'h0, k == 0});
        chk("eop", {31'h0, bus.endofpacket_out}, {31'h0, k == N - 1});
        if (k == N - 1) begin
          done = 1;
          frame_end();
        end
        k++;
      end
      stall = bus.valid_out && !bus.ready_in;
      held  = now;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    chk("xfers", k, N);
  endtask

  task automatic after_frame();
    chk("cont_valid", {31'h0, bus.valid_out}, {31'h0, m_en});
    if (m_en) chk("b2b_sop", {31'h0, bus.startofpacket_out}, 32'd1);
  endtask

  initial begin
    logic [1:0]  rp;
    logic [15:0] rc;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    bus.ready_in   = 1'b0;
    m_en = 0; m_ss = 0; m_pat = 2'd0; m_col = 16'h0; m_fc = 0;
    clear_acts();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, bus.valid_out}, 32'd0);
    chk("rst_sop", {31'h0, bus.startofpacket_out}, 32'd0);
    chk("rst_eop", {31'h0, bus.endofpacket_out}, 32'd0);
    chk("rst_data", {16'h0, bus.data_out}, 32'd0);
    mm_read("rst_reg0", 2'd0, 32'h0);
    mm_read("rst_reg1", 2'd1, 32'h0);
    mm_read("rst_reg2", 2'd2, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    mm_write(2'd1, {16'hF800, 14'h0, 2'd0});
    mm_read("reg1_rb", 2'd1, reg1_val());
    mm_write(2'd3, 32'hFFFF_FFFF);
    mm_read("reg3_rb", 2'd3, 32'h0);
    chk("rd_idle", bus.readdata, 32'h0);

    // solid F800, switch to bars mid-frame for the next frame
    start(32'h1);
    act_beat[0] = 5; act_addr[0] = 2'd1; act_data[0] = {16'hF800, 14'h0, 2'd1};
    stream_frame(100, -1);
    clear_acts();
    after_frame();

    // bars, queue checkerboard for the next frame
    act_beat[0] = 5; act_addr[0] = 2'd1; act_data[0] = {16'h1234, 14'h0, 2'd3};
    stream_frame(100, -1);
    clear_acts();
    after_frame();

    // checkerboard at 50% ready; disable at 10, pattern 2 at 20
    act_beat[0] = 10; act_addr[0] = 2'd0; act_data[0] = 32'h0;
    act_beat[1] = 20; act_addr[1] = 2'd1; act_data[1] = {16'h1234, 14'h0, 2'd2};
    stream_frame(50, -1);
    clear_acts();
    after_frame();
    repeat (3) @(negedge clk);
    chk("idle_valid", {31'h0, bus.valid_out}, 32'd0);
    mm_read("idle_reg2", 2'd2, reg2_val(1'b0));
    mm_read("idle_reg0", 2'd0, 32'h0);

    // single-shot grey ramp
    start(32'h3);
    mm_read("ss_reg0", 2'd0, 32'h3);
    mm_read("ss_busy", 2'd2, reg2_val(1'b1));
    stream_frame(70, -1);
    after_frame();
    mm_read("ss_done_reg0", 2'd0, 32'h0);
    mm_read("ss_done_reg2", 2'd2, reg2_val(1'b0));

    // random single-shot frames
    for (int r = 0; r < 4; r++) begin
      rp = 2'($urandom_range(0, 3));
      rc = 16'($urandom);
      mm_write(2'd1, {rc, 14'h0, rp});
      start(32'h3);
      stream_frame(int'($urandom_range(30, 100)), -1);
      after_frame();
      mm_read("rnd_reg2", 2'd2, reg2_val(1'b0));
    end

    // reset while stalled at beat 30
    mm_write(2'd1, {16'h07E0, 14'h0, 2'd0});
    start(32'h1);
    stream_frame(100, 30);
    @(posedge clk);
    @(negedge clk);
    m_en = 0; m_ss = 0; m_pat = 2'd0; m_col = 16'h0; m_fc = 0;
    chk("rstmid_valid", {31'h0, bus.valid_out}, 32'd0);
    chk("rstmid_eop", {31'h0, bus.endofpacket_out}, 32'd0);
    mm_read("rstmid_reg2", 2'd2, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    mm_read("rstmid_reg1", 2'd1, 32'h0);

    // restart from sop, disable early so the frame ends cleanly
    mm_write(2'd1, {16'h001F, 14'h0, 2'd3});
    start(32'h1);
    act_beat[0] = 40; act_addr[0] = 2'd0; act_data[0] = 32'h0;
    stream_frame(60, -1);
    clear_acts();
    after_frame();
    mm_read("final_reg2", 2'd2, reg2_val(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
